// File: rtl/aes_rounds.sv
// AES-128 encryption datapath. The initial AddRoundKey and all ten cipher
// rounds are evaluated combinationally from a pre-expanded key schedule, and
// the ciphertext is registered once. Byte i of any 128-bit word is bits
// [8i:8i+7] (MSB first); the state is column-major: state[row][col] = byte 4col+row.

// Forward S-box lookup for one byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Row k of the text below holds entries 16k..16k+15; index 0 is leftmost.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];
endmodule

// One cipher round: SubBytes, ShiftRows, MixColumns (skipped when FINAL),
// then AddRoundKey.
module aes_round #(
  parameter bit FINAL = 1'b0
) (
  input  logic [0:15][7:0] st_in,
  input  logic [0:15][7:0] rk,
  output logic [0:15][7:0] st_out
);
  logic [0:15][7:0] sb;
  logic [0:15][7:0] sr;

  // GF(2^8) multiply-by-two with the AES reduction polynomial.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Sixteen private S-boxes per round; nothing is shared between rounds.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a(st_in[i]), .y(sb[i]));
  end

  // Row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  if (FINAL) begin : g_last
    assign st_out = sr ^ rk;
  end else begin : g_mid
    logic [0:15][7:0] mc;
    for (genvar c = 0; c < 4; c++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[4*c];
      assign a1 = sr[4*c+1];
      assign a2 = sr[4*c+2];
      assign a3 = sr[4*c+3];
      assign mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      assign mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      assign mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      assign mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    assign st_out = mc ^ rk;
  end
endmodule

// Top: whitening plus the ten-round chain, one output register stage.
module aes_rounds (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:1407] schedule,
  input  logic [0:127]  data,
  input  logic          data_valid,
  output logic [0:127]  round_out,
  output logic          out_valid
);
  logic [0:10][0:15][7:0] rk;
  logic [0:15][7:0]       st0;

  // Round key r is the r-th 128-bit slice counting from bit 0.
  assign rk  = schedule;
  assign st0 = data ^ rk[0];

  // Each round owns its own wires so the chain never loops through one variable.
  for (genvar r = 1; r <= 10; r++) begin : g_round
    logic [0:15][7:0] st_in;
    logic [0:15][7:0] st_out;
    if (r == 1) begin : g_first
      assign st_in = st0;
    end else begin : g_next
      assign st_in = g_round[r-1].st_out;
    end
    aes_round #(.FINAL(r == 10)) u_round (
      .st_in (st_in),
      .rk    (rk[r]),
      .st_out(st_out)
    );
  end

  // Capture ciphertext on accepted blocks; hold it otherwise, reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= data_valid;
      if (data_valid) round_out <= g_round[10].st_out;
    end
  end
endmodule

// File: tb/tb_aes_rounds.sv
// Bench for aes_rounds: FIPS-197 known answers, back-to-back, reset and
// random blocks checked against an independent software AES-128 model.
module tb_aes_rounds;
  logic          tb_clk = 1'b0;
  logic          reset;
  logic [0:1407] schedule;
  logic [0:127]  data;
  logic          data_valid;
  logic [0:127]  round_out;
  logic          out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [0:127] exp_q[$];
  logic [0:127] hold;
  logic [7:0]   sb_t[256];

  aes_rounds dut (
    .clk       (tb_clk),
    .reset     (reset),
    .schedule  (schedule),
    .data      (data),
    .data_valid(data_valid),
    .round_out (round_out),
    .out_valid (out_valid)
  );

  always #5 tb_clk = ~tb_clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box derived from the field inverse and the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:1407] expand(input logic [0:127] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rcon = 8'h01;
    logic [0:1407] s;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  function automatic logic [0:127] cipher(input logic [0:127] d, input logic [0:1407] sch);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [0:127] o;
    for (int i = 0; i < 16; i++) s[i] = d[8*i +: 8] ^ sch[8*i +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ sch[128*r + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction

  // Drive one cycle; push the expected ciphertext when a block is accepted,
  // then check outputs #1 after the edge against the scoreboard.
  task automatic step(input string tag, input logic v, input logic rst,
                      input logic [0:127] d, input logic [0:1407] sch,
                      input logic [0:127] expd);
    logic [0:127] e;
    reset = rst; data_valid = v; data = d; schedule = sch;
    if (v && !rst) exp_q.push_back(expd);
    @(posedge tb_clk); #1;
    if (rst) hold = '0;
    n_cmp++;
    assert (out_valid === (v && !rst)) else begin
      n_fail++;
      $error("FAIL %s valid: observed %b expected %b", tag, out_valid, v && !rst);
    end
    if (v && !rst) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      hold = e;
    end
    n_cmp++;
    assert (round_out === hold) else begin
      n_fail++;
      $error("FAIL %s data: observed %h expected %h", tag, round_out, hold);
    end
  endtask

  initial begin
    logic [0:1407] sch_b, sch_c, sch_z, sch_r;
    logic [0:127]  pt_b, pt_c, ct_b, ct_c, pt_r, key_r;
    reset = 1'b1; data_valid = 1'b0; data = '0; schedule = '0; hold = '0;
    build_sbox();
    pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
    ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
    pt_c  = 128'h00112233445566778899aabbccddeeff;
    ct_c  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    sch_b = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    sch_c = expand(128'h000102030405060708090a0b0c0d0e0f);
    sch_z = expand(128'h0);

    step("reset0", 1'b0, 1'b1, '0, '0, '0);
    step("reset1", 1'b0, 1'b1, '0, '0, '0);
    step("app_b", 1'b1, 1'b0, pt_b, sch_b, ct_b);
    step("idle_b", 1'b0, 1'b0, '0, '0, '0);
    step("app_c1", 1'b1, 1'b0, pt_c, sch_c, ct_c);
    step("zero", 1'b1, 1'b0, '0, sch_z, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    // Back-to-back B then C.1, then idle with C.1 held.
    step("b2b_b", 1'b1, 1'b0, pt_b, sch_b, ct_b);
    step("b2b_c1", 1'b1, 1'b0, pt_c, sch_c, ct_c);
    step("b2b_hold", 1'b0, 1'b0, pt_b, sch_b, '0);
    // Reset wins over a valid block, then B is accepted normally.
    step("rst_mid", 1'b1, 1'b1, pt_c, sch_c, ct_c);
    step("after_rst", 1'b1, 1'b0, pt_b, sch_b, ct_b);

    for (int n = 0; n < 1000; n++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      sch_r = expand(key_r);
      if ($urandom_range(0, 7) == 0)
        step("rand_idle", 1'b0, 1'b0, pt_r, sch_r, '0);
      step("rand", 1'b1, 1'b0, pt_r, sch_r, cipher(pt_r, sch_r));
    end
    step("final_idle", 1'b0, 1'b0, '0, '0, '0);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
